// File: rtl/sprite_pkg.sv
// Shared types and constant tables for the animated sprite renderer: RGB
// struct, enemy bee bitmaps (two animation frames) and the two palettes.
package sprite_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

    localparam int BEE_W      = 9;
    localparam int BEE_H      = 7;
    localparam int BEE_FRAMES = 2;
    localparam int BEE_BITS_W = 2 * BEE_W * BEE_H * BEE_FRAMES;

    // Frame 0 row 0 sits at the MSB end; within a row column 0 is leftmost.
    // 0 = transparent, 1 = yellow, 2 = blue wing, 3 = red. Frame 1 folds the wings.
    localparam logic [BEE_BITS_W-1:0] BEE_BITS = {
        18'b00_00_00_01_01_01_00_00_00,
        18'b00_10_10_01_11_01_10_10_00,
        18'b10_10_10_11_01_11_10_10_10,
        18'b00_10_01_01_11_01_01_10_00,
        18'b00_00_11_01_01_01_11_00_00,
        18'b00_00_00_11_01_11_00_00_00,
        18'b00_00_00_00_11_00_00_00_00,
        18'b00_00_00_01_01_01_00_00_00,
        18'b00_00_00_01_11_01_00_00_00,
        18'b00_00_10_11_01_11_10_00_00,
        18'b00_00_01_01_11_01_01_00_00,
        18'b00_00_11_01_01_01_11_00_00,
        18'b00_00_00_11_01_11_00_00_00,
        18'b00_00_00_00_11_00_00_00_00
    };

    function automatic rgb_t pal_lookup(input int pal, input logic [1:0] idx);
        logic [23:0] c;
        c = 24'h000000;
        if (pal == 1) begin
            case (idx)
                2'd1:    c = 24'hF80000;
                2'd2:    c = 24'hF8E800;
                2'd3:    c = 24'h00E8F8;
                default: c = 24'h000000;
            endcase
        end else begin
            case (idx)
                2'd1:    c = 24'hF8E800;
                2'd2:    c = 24'h0050F8;
                2'd3:    c = 24'hF80000;
                default: c = 24'h000000;
            endcase
        end
        return rgb_t'(c);
    endfunction

endpackage

// File: rtl/sprite_index_rom.sv
// Registered bitmap lookup: frame/row/col -> 2-bit palette index, one cycle later.
module sprite_index_rom
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 9,
    parameter int SPR_H      = 7,
    parameter int NUM_FRAMES = 2,
    parameter int FW         = 1,
    parameter int RW         = 3,
    parameter int CW         = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [FW-1:0] frame_i,
    input  logic [RW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    output logic [1:0]    idx_o
);

    logic [1:0] idx_d, idx_q;
    int         k;
    int         sh;

    // Out-of-box addresses only occur for missed pixels; read them as transparent.
    always_comb begin
        idx_d = 2'd0;
        k     = (int'(frame_i) * SPR_H + int'(row_i)) * SPR_W + int'(col_i);
        sh    = BEE_BITS_W - 2 - 2 * k;
        if (int'(frame_i) < NUM_FRAMES && int'(frame_i) < BEE_FRAMES &&
            int'(row_i) < SPR_H && int'(col_i) < SPR_W && sh >= 0) begin
            idx_d = 2'(BEE_BITS >> sh);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) idx_q <= 2'd0;
        else       idx_q <= idx_d;
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/anim_sprite_renderer.sv
// Two-stage sprite pixel pipeline: beam-vs-origin hit test and bitmap address
// in stage 1, palette mapping to registered RGB in stage 2; vsync-driven animation.
module anim_sprite_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W      = 9,
    parameter int SPR_H      = 7,
    parameter int NUM_FRAMES = 2,
    parameter int NUM_PAL    = 2,
    parameter int ANIM_DIV   = 8,
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    localparam int PW = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_tick,
    input  logic          anim_en,
    input  logic          flip_x,
    input  logic          scale2x,
    input  logic [PW-1:0] pal_sel,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic          pix_valid_in,
    output logic          sprite_on,
    output logic [7:0]    sprite_r,
    output logic [7:0]    sprite_g,
    output logic [7:0]    sprite_b,
    output logic          pix_valid_out,
    output logic [FW-1:0] anim_frame
);

    localparam int CW = $clog2(SPR_W);
    localparam int RW = $clog2(SPR_H);
    localparam int TW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [TW-1:0] tick_d, tick_q;
    logic [FW-1:0] frame_d, frame_q;

    always_comb begin
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_tick && anim_en) begin
            if (tick_q == TW'(ANIM_DIV - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
            end else begin
                tick_d = tick_q + TW'(1);
            end
        end
    end

    // Offsets are 11-bit so a beam left of / above the origin wraps large and misses.
    logic [10:0]   dx, dy, lim_w, lim_h;
    logic [CW-1:0] col_raw, col_d;
    logic [RW-1:0] row_d;
    logic          hit_d;

    always_comb begin
        dx      = {1'b0, draw_x} - {1'b0, pos_x};
        dy      = {1'b0, draw_y} - {1'b0, pos_y};
        lim_w   = scale2x ? 11'(2 * SPR_W) : 11'(SPR_W);
        lim_h   = scale2x ? 11'(2 * SPR_H) : 11'(SPR_H);
        hit_d   = pix_valid_in && (dx < lim_w) && (dy < lim_h);
        col_raw = CW'(dx >> scale2x);
        row_d   = RW'(dy >> scale2x);
        col_d   = flip_x ? CW'(SPR_W - 1) - col_raw : col_raw;
    end

    // The ROM register doubles as the stage-1 index register, so the frame is
    // captured with the pixel and a later tick cannot affect it.
    logic [1:0]    idx1_q;
    logic          hit1_q, vld1_q;
    logic [PW-1:0] pal1_q;

    sprite_index_rom #(
        .SPR_W      (SPR_W),
        .SPR_H      (SPR_H),
        .NUM_FRAMES (NUM_FRAMES),
        .FW         (FW),
        .RW         (RW),
        .CW         (CW)
    ) u_rom (
        .Clk     (Clk),
        .Reset   (Reset),
        .frame_i (frame_q),
        .row_i   (row_d),
        .col_i   (col_d),
        .idx_o   (idx1_q)
    );

    rgb_t pix_rgb, rgb2_d, rgb2_q;
    logic on2_d, on2_q, vld2_q;

    always_comb begin
        pix_rgb = pal_lookup(int'(pal1_q), idx1_q);
        on2_d   = hit1_q && (idx1_q != 2'd0);
        rgb2_d  = on2_d ? pix_rgb : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_q  <= '0;
            frame_q <= '0;
            hit1_q  <= 1'b0;
            vld1_q  <= 1'b0;
            pal1_q  <= '0;
            on2_q   <= 1'b0;
            rgb2_q  <= '0;
            vld2_q  <= 1'b0;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
            hit1_q  <= hit_d;
            vld1_q  <= pix_valid_in;
            pal1_q  <= pal_sel;
            on2_q   <= on2_d;
            rgb2_q  <= rgb2_d;
            vld2_q  <= vld1_q;
        end
    end

    assign sprite_on     = on2_q;
    assign sprite_r      = rgb2_q.r;
    assign sprite_g      = rgb2_q.g;
    assign sprite_b      = rgb2_q.b;
    assign pix_valid_out = vld2_q;
    assign anim_frame    = frame_q;

endmodule

// File: doc/anim_sprite_renderer.md
Name: anim_sprite_renderer

Overview:
Parametrised, pipelined successor to the fixed per-enemy sprite lookups. It stores palette-indexed bitmaps for several animation frames and compares the VGA beam position against a sprite origin. It outputs registered RGB plus an opaque flag for the colour mapper. It supports animation stepping on vertical-sync ticks, horizontal flip, 2x scaling and palette selection. One instance is used per on-screen sprite slot.

Parameters:
SPR_W, 9, sprite width in source pixels
SPR_H, 7, sprite height in source pixels
NUM_FRAMES, 2, animation frames stored in the ROM
NUM_PAL, 2, selectable palettes of 4 entries each
ANIM_DIV, 8, frame_tick pulses per animation step (>=1)

Ports:
Clk  in  1  pixel clock
Reset  in  1  asynchronous, active-high reset
frame_tick  in  1  one-cycle pulse per vertical sync
anim_en  in  1  animation advance enable
flip_x  in  1  mirror sprite horizontally
scale2x  in  1  draw each source pixel as 2x2
pal_sel  in  $clog2(NUM_PAL)  palette select
pos_x  in  10  sprite top-left X on screen
pos_y  in  10  sprite top-left Y on screen
draw_x  in  10  beam X
draw_y  in  10  beam Y
pix_valid_in  in  1  beam is in the active area
sprite_on  out  1  opaque sprite pixel at this beam position
sprite_r  out  8  red
sprite_g  out  8  green
sprite_b  out  8  blue
pix_valid_out  out  1  pix_valid_in delayed to align with the outputs
anim_frame  out  $clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (asynchronous, any cycle): all outputs 0, tick counter 0, anim_frame 0, pipeline valid bits cleared. The first outputs after Reset deasserts come from fresh inputs only.
- Pipeline latency is exactly 2 cycles, from draw_x/draw_y/pix_valid_in to all outputs. Throughput is 1 pixel per cycle with no stalls.
- Stage 1 (registered):
  - dx = draw_x - pos_x, dy = draw_y - pos_y, computed at 11 bits unsigned. A beam left of or above the origin wraps large and therefore misses.
  - s = scale2x ? 2 : 1.
  - hit = pix_valid_in & (dx < SPR_W*s) & (dy < SPR_H*s).
  - col = dx>>scale2x and row = dy>>scale2x.
  - If flip_x, col = SPR_W-1-col.
  - Latch hit, col, row, pal_sel and anim_frame.
- Stage 2 (registered):
  - idx = ROM[frame][row][col], 2 bits.
  - RGB = palette[pal_sel][idx].
  - sprite_on = hit & (idx != 0).
  - If sprite_on is 0, RGB outputs are forced to 0.
- Animation:
  - Applies on a frame_tick cycle with anim_en=1. If tick_cnt == ANIM_DIV-1, tick_cnt becomes 0 and anim_frame becomes (anim_frame+1) mod NUM_FRAMES; otherwise tick_cnt increments.
  - With anim_en=0, ticks are ignored and both tick_cnt and anim_frame hold.
  - A frame_tick while hit pixels are in flight is allowed. Pixels already past stage 1 keep the frame they latched.
- Off-screen sprites: pos_x up to 1023 or pos_y up to 1023 is legal. Portions beyond 639/479 are simply never hit. There is no wrap to the left or top edge.
- pos_x, pos_y, flip_x, scale2x and pal_sel may change on any cycle and take effect for the pixel sampled in that cycle.
- ROM index 0 is always transparent, regardless of palette.

Decomposition:
- Package sprite_pkg:
  - typedef rgb_t (struct of r, g, b, 8 bits each).
  - The frame/row/col index table for the enemy bee. Frame 0 is the current bee bitmap mapped to indices: 1 = F8E800 yellow, 2 = 0050F8 blue, 3 = F80000 red. Frame 1 has wings folded.
  - Palette table: palette 0 = {000000, F8E800, 0050F8, F80000}; palette 1 = {000000, F80000, F8E800, 00E8F8}.
  - Screen constants 640/480.
- Sub-module sprite_index_rom: registered lookup of frame/row/col -> 2-bit index, used for stage 2.

Test Plan:
- Reset: assert Reset mid-line with a hit in flight -> outputs 0 immediately. After release, the first valid pixel appears exactly 2 cycles after its input.
- Opaque and transparent pixels: pos=(100,50), pal 0, frame 0. Beam (104,50) -> 2 cycles later sprite_on=1, RGB=F8/E8/00. Beam (100,50) -> sprite_on=0, RGB=0.
- Box edges: beam (108,56) hits; beams (109,56), (99,50) and (104,57) all miss. With pix_valid_in=0 at (104,50) -> sprite_on=0.
- Flip and scale: flip_x=1, beam (104,50) -> same as the unflipped centre pixel; beam (100,50) maps to col 8. With scale2x=1, beams (108,50) and (109,51) both map to source (4,0) with identical RGB; (118,50) misses.
- Animation: ANIM_DIV=8, anim_en=1. After 7 ticks anim_frame=0; the 8th tick gives 1; the 16th tick gives 0 (wrap). With anim_en=0, 20 ticks leave the frame unchanged.
- Palette and clipping: pal_sel=1, pixel idx 1 -> RGB F80000. pos_x=636 -> only beam columns 636..639 are ever hit, with no wrap to x=0..4.
